// File: rtl/alu_muldiv_ctrl_if.sv
// rtl/alu_muldiv_ctrl_if.sv - EX-stage decode and mul/div bus between pipeline and alu_muldiv_ctrl
interface alu_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       ALUOp;
    logic [5:0]       funct;
    logic             op_valid;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [3:0]       ALUCtrl;
    logic             hilo_sel;
    logic [WIDTH-1:0] hilo_rdata;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output ALUOp, funct, op_valid, src_a, src_b,
        input  ALUCtrl, hilo_sel, hilo_rdata, stall, busy, hi, lo
    );

    modport slave (
        input  ALUOp, funct, op_valid, src_a, src_b,
        output ALUCtrl, hilo_sel, hilo_rdata, stall, busy, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// rtl/alu_muldiv_ctrl.sv - ALU control decoder with iterative multiply/divide and HI/LO registers
module alu_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    alu_muldiv_ctrl_if.slave  bus
);
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTLO = 6'b010011;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d, rem_q, rem_d, quo_q, quo_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d, b_raw_q, b_raw_d;
    logic [5:0]       funct_q, funct_d;
    logic             is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
    logic             dz_q, dz_d, done_q, done_d;

    logic             is_r, is_md, is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic             same_instr, start, sgn_op, sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b, quo_fix, rem_fix;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign is_r    = (bus.ALUOp == 2'b10);
    assign is_md   = is_r && (bus.funct[5:2] == 4'b0110);
    assign is_mfhi = is_r && (bus.funct == F_MFHI);
    assign is_mflo = is_r && (bus.funct == F_MFLO);
    assign is_mthi = is_r && (bus.funct == F_MTHI);
    assign is_mtlo = is_r && (bus.funct == F_MTLO);

    // The done flag keeps a finished mul/div, still parked in EX, from starting again.
    assign same_instr = bus.op_valid && is_md && (bus.funct == funct_q)
                        && (bus.src_a == a_raw_q) && (bus.src_b == b_raw_q);
    assign start = !rst && bus.op_valid && is_md && (state_q == IDLE) && !(done_q && same_instr);

    assign sgn_op = ~bus.funct[0];
    assign sa     = sgn_op & bus.src_a[WIDTH-1];
    assign sb     = sgn_op & bus.src_b[WIDTH-1];
    assign abs_a  = sa ? -bus.src_a : bus.src_a;
    assign abs_b  = sb ? -bus.src_b : bus.src_b;

    assign mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};

    assign prod     = {rem_q, quo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -quo_q : quo_q;
    assign rem_fix  = rneg_q ? -rem_q : rem_q;

    always_comb begin
        bus.ALUCtrl = 4'b1111;
        case (bus.ALUOp)
            2'b00: bus.ALUCtrl = 4'b0010;
            2'b01: bus.ALUCtrl = 4'b0110;
            2'b11: bus.ALUCtrl = 4'b0000;
            default: begin
                case (bus.funct)
                    6'b100000: bus.ALUCtrl = 4'b0010;
                    6'b100010: bus.ALUCtrl = 4'b0110;
                    6'b100100: bus.ALUCtrl = 4'b0000;
                    6'b100101: bus.ALUCtrl = 4'b0001;
                    6'b101010: bus.ALUCtrl = 4'b0111;
                    6'b100110: bus.ALUCtrl = 4'b0011;
                    6'b100111: bus.ALUCtrl = 4'b1100;
                    6'b101011: bus.ALUCtrl = 4'b1000;
                    6'b000000: bus.ALUCtrl = 4'b1001;
                    6'b000010: bus.ALUCtrl = 4'b1010;
                    6'b000011: bus.ALUCtrl = 4'b1011;
                    default:   bus.ALUCtrl = 4'b1111;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        a_raw_d  = a_raw_q;
        b_raw_d  = b_raw_q;
        funct_d  = funct_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        done_d   = done_q && same_instr;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = CNT_W'(WIDTH);
                    is_div_d = bus.funct[1];
                    neg_d    = sa ^ sb;
                    rneg_d   = sa;
                    dz_d     = (bus.src_b == '0);
                    opnd_d   = bus.funct[1] ? abs_b : abs_a;
                    quo_d    = bus.funct[1] ? abs_a : abs_b;
                    rem_d    = '0;
                    a_raw_d  = bus.src_a;
                    b_raw_d  = bus.src_b;
                    funct_d  = bus.funct;
                end else if (bus.op_valid && is_mthi) begin
                    hi_d = bus.src_a;
                end else if (bus.op_valid && is_mtlo) begin
                    lo_d = bus.src_a;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    // Restoring step: keep the trial difference only when it did not borrow.
                    if (!div_trial[WIDTH]) begin
                        rem_d = div_trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    rem_d = mul_sum[WIDTH:1];
                    quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q && dz_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;    cnt_q    <= '0;
            hi_q    <= '0;      lo_q     <= '0;
            opnd_q  <= '0;      rem_q    <= '0;   quo_q  <= '0;
            a_raw_q <= '0;      b_raw_q  <= '0;   funct_q <= '0;
            is_div_q <= 1'b0;   neg_q    <= 1'b0; rneg_q <= 1'b0;
            dz_q    <= 1'b0;    done_q   <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q    <= cnt_d;
            hi_q    <= hi_d;    lo_q     <= lo_d;
            opnd_q  <= opnd_d;  rem_q    <= rem_d;  quo_q  <= quo_d;
            a_raw_q <= a_raw_d; b_raw_q  <= b_raw_d; funct_q <= funct_d;
            is_div_q <= is_div_d; neg_q  <= neg_d;  rneg_q <= rneg_d;
            dz_q    <= dz_d;    done_q   <= done_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.stall      = start || (!rst && bus.busy && bus.op_valid
                            && (is_md || is_mfhi || is_mflo || is_mthi || is_mtlo));
    assign bus.hilo_sel   = bus.op_valid && (is_mfhi || is_mflo);
    assign bus.hilo_rdata = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb/tb_alu_muldiv_ctrl.sv - directed scoreboard bench for alu_muldiv_ctrl
module tb_alu_muldiv_ctrl;
    localparam int W = 32;

    typedef struct {
        string       tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    alu_muldiv_ctrl_if #(.WIDTH(W)) bus ();

    alu_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.op_valid = 1'b0;
        bus.ALUOp    = 2'b00;
        bus.funct    = 6'b000000;
        bus.src_a    = '0;
        bus.src_b    = '0;
    endtask

    task automatic present(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.ALUOp    = 2'b10;
        bus.funct    = f;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.op_valid = 1'b1;
    endtask

    // Drives one mul/div, holds it in EX across the stall, and scores the HI/LO result.
    task automatic md_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int busy_n;
        int stall_n;
        int guard;
        exp_t e;
        tick();
        exp_q.push_back('{tag, ehi, elo});
        present(f, a, b);
        #1;
        check({tag, "_start_stall"}, 64'(bus.stall), 64'(1));
        busy_n = 0; stall_n = 0; guard = 0;
        do begin
            tick();
            if (bus.busy) busy_n++;
            if (bus.busy && bus.stall) stall_n++;
            guard++;
        end while (bus.busy && guard < 100);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(W + 1));
        check({tag, "_stall_cycles"}, 64'(stall_n), 64'(W + 1));
        check({tag, "_stall_after"}, 64'(bus.stall), 64'(0));
        e = exp_q.pop_front();
        check({e.tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
        check({e.tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
        tick();
        check({tag, "_no_restart"}, 64'(bus.busy), 64'(0));
        idle_bus();
    endtask

    logic [5:0] fn_tbl [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h26, 6'h27, 6'h2B, 6'h00, 6'h02, 6'h03};
    logic [3:0] ct_tbl [11] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'h3, 4'hC, 4'h8, 4'h9, 4'hA, 4'hB};

    initial begin
        int n;
        exp_t e;
        idle_bus();
        tick();
        tick();
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_stall", 64'(bus.stall), 64'(0));
        rst = 1'b0;

        bus.ALUOp = 2'b10;
        for (int i = 0; i < 11; i++) begin
            bus.funct = fn_tbl[i];
            #1;
            check($sformatf("dec_f%02h", fn_tbl[i]), 64'(bus.ALUCtrl), 64'(ct_tbl[i]));
        end
        bus.funct = 6'b011000; #1;
        check("dec_mult", 64'(bus.ALUCtrl), 64'(4'hF));
        bus.funct = 6'b010000; #1;
        check("dec_mfhi", 64'(bus.ALUCtrl), 64'(4'hF));
        bus.ALUOp = 2'b00; #1;
        check("dec_op00", 64'(bus.ALUCtrl), 64'(4'h2));
        bus.ALUOp = 2'b01; #1;
        check("dec_op01", 64'(bus.ALUCtrl), 64'(4'h6));
        bus.ALUOp = 2'b11; #1;
        check("dec_op11", 64'(bus.ALUCtrl), 64'(4'h0));
        idle_bus();

        md_op("mult_neg", 6'b011000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        md_op("divu", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14);
        md_op("div_neg", 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md_op("div_zero", 6'b011010, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        md_op("div_ovf", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        md_op("multu_big", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

        tick();
        exp_q.push_back('{"mflo_wait", 32'd0, 32'd42});
        present(6'b011000, 32'd6, 32'd7);
        tick();
        bus.funct = 6'b010010;
        #1;
        n = 0;
        for (int i = 0; i < 100 && bus.stall; i++) begin
            n++;
            tick();
        end
        check("mflo_stall_cycles", 64'(n), 64'(W + 1));
        e = exp_q.pop_front();
        check("mflo_sel", 64'(bus.hilo_sel), 64'(1));
        check({e.tag, "_rdata"}, 64'(bus.hilo_rdata), 64'(e.lo));
        idle_bus();

        tick();
        present(6'b010011, 32'h0000_00A5, 32'd0);
        #1;
        check("mtlo_stall", 64'(bus.stall), 64'(0));
        tick();
        check("mtlo_lo", 64'(bus.lo), 64'(32'hA5));
        present(6'b010001, 32'hDEAD_BEEF, 32'd0);
        tick();
        check("mthi_hi", 64'(bus.hi), 64'(32'hDEAD_BEEF));
        bus.funct = 6'b010000;
        #1;
        check("mfhi_rdata", 64'(bus.hilo_rdata), 64'(32'hDEAD_BEEF));
        idle_bus();

        tick();
        present(6'b011001, 32'h0001_2345, 32'h0000_6789);
        tick();
        for (int i = 0; i < 9; i++) tick();
        check("abort_busy_before", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        tick();
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_stall", 64'(bus.stall), 64'(0));
        check("abort_hi", 64'(bus.hi), 64'(0));
        check("abort_lo", 64'(bus.lo), 64'(0));
        idle_bus();
        rst = 1'b0;

        md_op("multu_small", 6'b011001, 32'd3, 32'd4, 32'd0, 32'd12);

        check("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
